// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared elaboration helpers for the pipelined ripple-carry adder
package rca_pkg;

  // True when WIDTH splits evenly into STAGES non-empty ripple segments.
  function automatic bit check_div(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_rca_adder_if.sv
// rtl/pipelined_rca_adder_if.sv - operand/result handshake bundle for pipelined_rca_adder
interface pipelined_rca_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry, ovf
  );
endinterface

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CHUNK-bit ripple-carry segment
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);
  logic [CHUNK:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o    = c[CHUNK];
  // Carry into the segment MSB; only the top segment's copy feeds overflow.
  assign msb_cin_o = c[CHUNK-1];
endmodule

// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - STAGES-deep pipelined ripple-carry adder with valid/ready
module pipelined_rca_adder
  import rca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_rca_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (!check_div(WIDTH, STAGES)) begin : g_param_err
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES (1..WIDTH)");
  end

  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            carry_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic                         ovf_q;

  logic [STAGES-1:0][CHUNK-1:0] ch_a;
  logic [STAGES-1:0][CHUNK-1:0] ch_b;
  logic [STAGES-1:0][CHUNK-1:0] ch_sum;
  logic [STAGES-1:0]            ch_cin;
  logic [STAGES-1:0]            ch_cout;
  logic [STAGES-1:0]            ch_msbc;

  logic [STAGES:0]              v_in;
  logic                         advance;
  logic                         unused_sink;

  // One global enable: the whole pipe moves together or holds together.
  assign advance = !valid_q[STAGES-1] || bus.out_ready;
  assign v_in    = {valid_q, bus.in_valid};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ch_a[k]   = bus.a[CHUNK-1:0];
      assign ch_b[k]   = bus.b[CHUNK-1:0];
      assign ch_cin[k] = bus.cin;
    end else begin : g_rest
      // Skew registers are pre-shifted so the pending chunk is always in the low bits.
      assign ch_a[k]   = a_q[k-1][CHUNK-1:0];
      assign ch_b[k]   = b_q[k-1][CHUNK-1:0];
      assign ch_cin[k] = carry_q[k-1];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i       (ch_a[k]),
      .b_i       (ch_b[k]),
      .cin_i     (ch_cin[k]),
      .sum_o     (ch_sum[k]),
      .cout_o    (ch_cout[k]),
      .msb_cin_o (ch_msbc[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= v_in[STAGES-1:0];
      if (bus.in_valid) begin
        sum_q[0]   <= WIDTH'(ch_sum[0]);
        carry_q[0] <= ch_cout[0];
        a_q[0]     <= bus.a >> CHUNK;
        b_q[0]     <= bus.b >> CHUNK;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (valid_q[k-1]) begin
          sum_q[k]                   <= sum_q[k-1];
          sum_q[k][k*CHUNK +: CHUNK] <= ch_sum[k];
          carry_q[k]                 <= ch_cout[k];
          a_q[k]                     <= a_q[k-1] >> CHUNK;
          b_q[k]                     <= b_q[k-1] >> CHUNK;
        end
      end
      if (v_in[STAGES-1]) begin
        ovf_q <= ch_msbc[STAGES-1] ^ ch_cout[STAGES-1];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.carry     = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  assign unused_sink = ^{a_q[STAGES-1], b_q[STAGES-1], ch_msbc, v_in[STAGES]};
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb/tb_pipelined_rca_adder.sv - directed and scoreboarded checks for pipelined_rca_adder
module tb_pipelined_rca_adder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipelined_rca_adder_if #(.WIDTH(16)) bus ();

  pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv, input logic c);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
  endtask

  task automatic single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic [15:0] es, input logic ec, input logic eo);
    drive(1'b1, av, bv, c);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.sum),       32'(es));
    chk({tag, "_carry"}, 32'(bus.carry),     32'(ec));
    chk({tag, "_ovf"},   32'(bus.ovf),       32'(eo));
    tick();
  endtask

  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic        vc [4];
  logic [15:0] vs [4];
  logic        vk [4];
  logic        vo [4];

  logic [15:0] q_sum [$];
  logic        q_car [$];
  logic        q_ovf [$];

  initial begin
    int sent;
    int rcvd;
    int cyc;
    logic [16:0] full;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_carry",     32'(bus.carry),     32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    single("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("negovf",  16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    single("cinprop", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);

    // back-to-back
    va = '{16'h1234, 16'h00FF, 16'hAAAA, 16'h0};
    vb = '{16'h1111, 16'h0001, 16'h5555, 16'h0};
    vs = '{16'h2345, 16'h0100, 16'hFFFF, 16'h0};
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, va[c], vb[c], 1'b0);
      else       drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      if (c >= 3) begin
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_sum",   32'(bus.sum),       32'(vs[c-3]));
        chk("b2b_carry", 32'(bus.carry),     32'd0);
        chk("b2b_ovf",   32'(bus.ovf),       32'd0);
      end
    end
    tick();
    chk("b2b_drain", 32'(bus.out_valid), 32'd0);

    // backpressure
    va = '{16'h0001, 16'h1000, 16'hFFFE, 16'h4000};
    vb = '{16'h0002, 16'h2000, 16'h0003, 16'h4000};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0};
    vs = '{16'h0003, 16'h3001, 16'h0001, 16'h8000};
    vk = '{1'b0, 1'b0, 1'b1, 1'b0};
    vo = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, va[c], vb[c], vc[c]);
      if (c == 3) bus.out_ready = 1'b0;
      tick();
    end
    drive(1'b1, 16'h5A5A, 16'h1111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_sum",      32'(bus.sum),       32'(vs[0]));
      chk("bp_carry",    32'(bus.carry),     32'(vk[0]));
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_rel_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_rel_sum",   32'(bus.sum),       32'(vs[c]));
      chk("bp_rel_carry", 32'(bus.carry),     32'(vk[c]));
      chk("bp_rel_ovf",   32'(bus.ovf),       32'(vo[c]));
      tick();
    end
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    // reset with ops in flight
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'h7000 + 16'(c), 16'h7000, 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_valid",    32'(bus.out_valid), 32'd0);
    chk("mrst_sum",      32'(bus.sum),       32'd0);
    chk("mrst_ovf",      32'(bus.ovf),       32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready),  32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // random traffic with scoreboard
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 2000 && cyc < 20000) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (sent < 2000 && $urandom_range(0, 9) < 7) begin
        ra = 16'($urandom());
        rb = 16'($urandom());
        rc = 1'($urandom());
        drive(1'b1, ra, rb, rc);
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0);
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        q_sum.push_back(full[15:0]);
        q_car.push_back(full[16]);
        q_ovf.push_back((ra[15] == rb[15]) && (full[15] != ra[15]));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q_sum.size() == 0) begin
          chk("rnd_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("rnd_sum",   32'(bus.sum),   32'(q_sum.pop_front()));
          chk("rnd_carry", 32'(bus.carry), 32'(q_car.pop_front()));
          chk("rnd_ovf",   32'(bus.ovf),   32'(q_ovf.pop_front()));
        end
        rcvd++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rnd_received", 32'(rcvd), 32'd2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
